// File: rtl/keynsham_prefetch.sv
// Instruction prefetch stage: one outstanding single-word bus read, a small FIFO of
// {instr, pc} entries towards decode, and flush/redirect on branch.
module keynsham_prefetch #(
  parameter logic [31:0] reset_vector = 32'h0000_0000,
  parameter int unsigned fifo_depth   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        i_access,
  output logic [29:0] i_addr,
  input  logic [31:0] i_data,
  input  logic        i_ack,
  input  logic        branch_valid,
  input  logic [31:0] branch_pc,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  input  logic        fetch_ready
);

  localparam int unsigned PtrW = $clog2(fifo_depth);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e          state_q, state_d;
  logic            access_q, access_d;
  logic [29:0]     addr_q, addr_d;
  logic [29:0]     next_addr_q, next_addr_d;
  logic            drop_q, drop_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [31:0]     instr_mem [fifo_depth];
  logic [29:0]     pc_mem    [fifo_depth];

  logic busy, acked, push, pop, issue;
  logic unused_pc_bits;

  assign unused_pc_bits = ^branch_pc[1:0];

  assign fetch_valid = (count_q != '0);
  assign fetch_instr = fetch_valid ? instr_mem[rd_ptr_q] : '0;
  assign fetch_pc    = fetch_valid ? {pc_mem[rd_ptr_q], 2'b00} : '0;
  assign i_access    = access_q;
  assign i_addr      = addr_q;

  always_comb begin
    busy  = (state_q == StWait);
    acked = busy && i_ack;
    push  = acked && !drop_q && !branch_valid;
    pop   = fetch_valid && fetch_ready && !branch_valid;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (branch_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end

    // Credit uses the post-push/pop count; nothing is outstanding after this
    // cycle whenever the bus is free to issue, so that term is always zero here.
    issue = !branch_valid && (!busy || i_ack) && (count_d < CntW'(fifo_depth));

    state_d     = state_q;
    access_d    = 1'b0;
    addr_d      = addr_q;
    next_addr_d = next_addr_q;
    drop_d      = drop_q;

    if (acked) drop_d = 1'b0;
    if (branch_valid) begin
      next_addr_d = branch_pc[31:2];
      // A stale request still in flight: its eventual ack must be discarded.
      if (busy && !i_ack) drop_d = 1'b1;
    end

    if (issue) begin
      access_d    = 1'b1;
      addr_d      = next_addr_q;
      next_addr_d = next_addr_q + 30'd1;
      state_d     = StWait;
    end else if (acked) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      access_q    <= 1'b0;
      addr_q      <= reset_vector[31:2];
      next_addr_q <= reset_vector[31:2];
      drop_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      access_q    <= access_d;
      addr_q      <= addr_d;
      next_addr_q <= next_addr_d;
      drop_q      <= drop_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset; visibility is governed by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= i_data;
      pc_mem[wr_ptr_q]    <= addr_q;
    end
  end

endmodule

// File: tb/tb_keynsham_prefetch.sv
// Directed bench for keynsham_prefetch: latency-configurable ROM slave on the main
// instance, plus a second instance with a wrapping reset vector.
module tb_keynsham_prefetch;

  logic        clk;
  logic        rst_n;
  logic        i_access, i_ack;
  logic [29:0] i_addr;
  logic [31:0] i_data;
  logic        branch_valid;
  logic [31:0] branch_pc;
  logic        fetch_valid, fetch_ready;
  logic [31:0] fetch_instr, fetch_pc;

  logic        i_access2, i_ack2;
  logic [29:0] i_addr2;
  logic [31:0] i_data2;
  logic        fetch_valid2;
  logic [31:0] fetch_instr2, fetch_pc2;

  int n_tests;
  int n_fail;
  int lat;

  keynsham_prefetch #(
    .reset_vector(32'h0000_0000),
    .fifo_depth  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_access    (i_access),
    .i_addr      (i_addr),
    .i_data      (i_data),
    .i_ack       (i_ack),
    .branch_valid(branch_valid),
    .branch_pc   (branch_pc),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_pc    (fetch_pc),
    .fetch_ready (fetch_ready)
  );

  keynsham_prefetch #(
    .reset_vector(32'hFFFF_FFF8),
    .fifo_depth  (4)
  ) dut_wrap (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_access    (i_access2),
    .i_addr      (i_addr2),
    .i_data      (i_data2),
    .i_ack       (i_ack2),
    .branch_valid(1'b0),
    .branch_pc   (32'h0),
    .fetch_valid (fetch_valid2),
    .fetch_instr (fetch_instr2),
    .fetch_pc    (fetch_pc2),
    .fetch_ready (1'b1)
  );

  function automatic logic [31:0] rom(input logic [29:0] a);
    return 32'h1000_0000 | {2'b00, a};
  endfunction

  // Slave: lat=1 acks in the access cycle; lat=N acks N-1 cycles after it.
  logic        pend_q;
  int          cnt_q;
  logic [29:0] paddr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= 1'b0;
      cnt_q   <= 0;
      paddr_q <= '0;
    end else if (i_access && lat > 1) begin
      pend_q  <= 1'b1;
      cnt_q   <= 1;
      paddr_q <= i_addr;
    end else if (pend_q) begin
      if (cnt_q == lat - 1) pend_q <= 1'b0;
      else                  cnt_q  <= cnt_q + 1;
    end
  end

  always_comb begin
    i_ack  = 1'b0;
    i_data = '0;
    if (i_access && lat == 1) begin
      i_ack  = 1'b1;
      i_data = rom(i_addr);
    end else if (pend_q && cnt_q == lat - 1) begin
      i_ack  = 1'b1;
      i_data = rom(paddr_q);
    end
  end

  assign i_ack2  = i_access2;
  assign i_data2 = i_access2 ? rom(i_addr2) : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int l, input logic ready);
    rst_n        = 1'b0;
    lat          = l;
    branch_valid = 1'b0;
    branch_pc    = '0;
    fetch_ready  = ready;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    lat          = 1;
    rst_n        = 1'b0;
    branch_valid = 1'b0;
    branch_pc    = '0;
    fetch_ready  = 1'b0;
    tick();
    tick();

    check_eq("rst_access", 32'(i_access), 32'd0);
    check_eq("rst_addr", 32'(i_addr), 32'd0);
    check_eq("rst_valid", 32'(fetch_valid), 32'd0);
    check_eq("rst_instr", fetch_instr, 32'd0);
    check_eq("rst_pc", fetch_pc, 32'd0);
    check_eq("rst_addr_wrap", 32'(i_addr2), 32'h3FFF_FFFE);
    rst_n = 1'b1;

    // Fill with decode stalled: addresses 0..3 back-to-back, then stop.
    tick();
    check_eq("fill_acc1", 32'(i_access), 32'd1);
    check_eq("fill_addr1", 32'(i_addr), 32'd0);
    check_eq("fill_valid1", 32'(fetch_valid), 32'd0);
    tick();
    check_eq("fill_acc2", 32'(i_access), 32'd1);
    check_eq("fill_addr2", 32'(i_addr), 32'd1);
    check_eq("fill_valid2", 32'(fetch_valid), 32'd1);
    check_eq("fill_pc2", fetch_pc, 32'h0);
    check_eq("fill_instr2", fetch_instr, 32'h1000_0000);
    tick();
    check_eq("fill_addr3", 32'(i_addr), 32'd2);
    tick();
    check_eq("fill_acc4", 32'(i_access), 32'd1);
    check_eq("fill_addr4", 32'(i_addr), 32'd3);
    tick();
    check_eq("full_acc5", 32'(i_access), 32'd0);
    tick();
    check_eq("full_acc6", 32'(i_access), 32'd0);
    check_eq("full_pc6", fetch_pc, 32'h0);
    fetch_ready = 1'b1;
    tick();
    fetch_ready = 1'b0;
    check_eq("pop1_acc", 32'(i_access), 32'd1);
    check_eq("pop1_addr", 32'(i_addr), 32'd4);
    check_eq("pop1_pc", fetch_pc, 32'h4);
    tick();
    check_eq("pop1_acc_after", 32'(i_access), 32'd0);
    tick();
    check_eq("pop1_acc_after2", 32'(i_access), 32'd0);
    check_eq("pop1_pc_hold", fetch_pc, 32'h4);

    // Streaming with decode always ready; wrap instance checked alongside.
    do_reset(1, 1'b1);
    tick();
    check_eq("stream_valid1", 32'(fetch_valid), 32'd0);
    check_eq("wrap_addr1", 32'(i_addr2), 32'h3FFF_FFFE);
    tick();
    check_eq("stream_pc2", fetch_pc, 32'h0);
    check_eq("wrap_addr2", 32'(i_addr2), 32'h3FFF_FFFF);
    check_eq("wrap_pc2", fetch_pc2, 32'hFFFF_FFF8);
    tick();
    check_eq("stream_pc3", fetch_pc, 32'h4);
    check_eq("wrap_addr3", 32'(i_addr2), 32'h0);
    check_eq("wrap_pc3", fetch_pc2, 32'hFFFF_FFFC);
    tick();
    check_eq("stream_pc4", fetch_pc, 32'h8);
    check_eq("wrap_pc4", fetch_pc2, 32'h0);
    check_eq("wrap_instr4", fetch_instr2, 32'h1000_0000);
    for (int n = 5; n < 10; n++) begin
      tick();
      check_eq($sformatf("stream_valid%0d", n), 32'(fetch_valid), 32'd1);
      check_eq($sformatf("stream_pc%0d", n), fetch_pc, 32'(4 * (n - 2)));
      check_eq($sformatf("stream_instr%0d", n), fetch_instr, 32'h1000_0000 + 32'(n - 2));
    end

    // Branch to 0x100 while a latency-3 request is in flight.
    do_reset(3, 1'b1);
    tick();
    check_eq("br3_acc1", 32'(i_access), 32'd1);
    tick();
    branch_valid = 1'b1;
    branch_pc    = 32'h100;
    tick();
    branch_valid = 1'b0;
    check_eq("br3_acc3", 32'(i_access), 32'd0);
    check_eq("br3_valid3", 32'(fetch_valid), 32'd0);
    tick();
    check_eq("br3_acc4", 32'(i_access), 32'd1);
    check_eq("br3_addr4", 32'(i_addr), 32'h40);
    check_eq("br3_valid4", 32'(fetch_valid), 32'd0);
    tick();
    check_eq("br3_valid5", 32'(fetch_valid), 32'd0);
    tick();
    check_eq("br3_valid6", 32'(fetch_valid), 32'd0);
    tick();
    check_eq("br3_valid7", 32'(fetch_valid), 32'd1);
    check_eq("br3_pc7", fetch_pc, 32'h100);
    check_eq("br3_instr7", fetch_instr, 32'h1000_0040);
    check_eq("br3_addr7", 32'(i_addr), 32'h41);

    // Two branches back to back while one stale request is outstanding.
    do_reset(4, 1'b1);
    tick();
    tick();
    branch_valid = 1'b1;
    branch_pc    = 32'h100;
    tick();
    branch_pc    = 32'h300;
    tick();
    branch_valid = 1'b0;
    check_eq("br2x_acc4", 32'(i_access), 32'd0);
    tick();
    check_eq("br2x_acc5", 32'(i_access), 32'd1);
    check_eq("br2x_addr5", 32'(i_addr), 32'hC0);
    check_eq("br2x_valid5", 32'(fetch_valid), 32'd0);
    tick();
    tick();
    tick();
    check_eq("br2x_valid8", 32'(fetch_valid), 32'd0);
    tick();
    check_eq("br2x_valid9", 32'(fetch_valid), 32'd1);
    check_eq("br2x_pc9", fetch_pc, 32'h300);
    check_eq("br2x_instr9", fetch_instr, 32'h1000_00C0);

    // Branch coinciding with an ack and a pop.
    do_reset(1, 1'b1);
    tick();
    tick();
    tick();
    check_eq("brack_pc3", fetch_pc, 32'h4);
    check_eq("brack_acc3", 32'(i_access), 32'd1);
    branch_valid = 1'b1;
    branch_pc    = 32'h200;
    tick();
    branch_valid = 1'b0;
    check_eq("brack_acc4", 32'(i_access), 32'd0);
    check_eq("brack_valid4", 32'(fetch_valid), 32'd0);
    tick();
    check_eq("brack_acc5", 32'(i_access), 32'd1);
    check_eq("brack_addr5", 32'(i_addr), 32'h80);
    check_eq("brack_valid5", 32'(fetch_valid), 32'd0);
    tick();
    check_eq("brack_valid6", 32'(fetch_valid), 32'd1);
    check_eq("brack_pc6", fetch_pc, 32'h200);
    check_eq("brack_instr6", fetch_instr, 32'h1000_0080);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
